// File: rtl/cache_mem_ctrl.sv
// rtl/cache_mem_ctrl.sv - latency-accurate block-granular main memory behind the cache
//
// Purpose: services one cache line fill or dirty-line writeback at a time.
//   A request is accepted in IDLE and held in internal registers. After
//   LATENCY edges the whole line is read into rd_line or written into
//   storage. ack then pulses for exactly one cycle.
// Ports:
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-low reset
//   req_valid       request present, held by the requester until ack
//   req_write       1 = writeback line, 0 = line fill
//   req_block_addr  block address; word base = addr * OFFSET_SIZE
//   wr_line         writeback data, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy            request accepted and not yet acked
//   ack             one-cycle completion pulse
//   rd_line         fill data, same packing as wr_line; held until next read ack
//   err             out-of-range access, valid with ack
// Configuration:
//   MEM_BOUNDS_CHECK_EN  when defined, out-of-range blocks are suppressed and
//                        flagged on err; otherwise the word base wraps modulo
//                        MEMORY_SIZE and err is tied low.
module cache_mem_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int OFFSET_SIZE      = 4,
  parameter int MEMORY_SIZE      = 1024,
  parameter int BLOCK_ADDR_WIDTH = 24,
  parameter int LATENCY          = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid,
  input  logic                              req_write,
  input  logic [BLOCK_ADDR_WIDTH-1:0]       req_block_addr,
  input  logic [OFFSET_SIZE*DATA_WIDTH-1:0] wr_line,
  output logic                              busy,
  output logic                              ack,
  output logic [OFFSET_SIZE*DATA_WIDTH-1:0] rd_line,
  output logic                              err
);

  localparam int OFF_BITS = (OFFSET_SIZE > 1) ? $clog2(OFFSET_SIZE) : 0;
  localparam int BASE_W   = BLOCK_ADDR_WIDTH + OFF_BITS;
  localparam int MEM_AW   = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int LINE_W   = OFFSET_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        busy_d, ack_d;
  logic                        capture, do_access;

  logic                        write_q;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
  logic [LINE_W-1:0]           wr_line_q;

  logic [BASE_W-1:0]           base_full;
  logic [MEM_AW-1:0]           mem_idx;
  logic                        oob;
  logic                        write_en;
  logic [LINE_W-1:0]           rd_next;
  logic [DATA_WIDTH-1:0]       mem_q [MEMORY_SIZE];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    ack_d     = 1'b0;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          ack_d     = 1'b1;
          state_d   = RESPOND;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      // req_valid deliberately not sampled here: the requester is still
      // dropping it in response to ack.
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- address path
  // The base is formed at full width so an out-of-range block is never
  // aliased before the bounds decision is made.
  assign base_full = BASE_W'(addr_q) << OFF_BITS;
  assign mem_idx   = MEM_AW'(base_full % BASE_W'(MEMORY_SIZE));

`ifdef MEM_BOUNDS_CHECK_EN
  logic [BASE_W:0] base_end;
  logic            err_q;

  assign base_end = {1'b0, base_full} + (BASE_W + 1)'(OFFSET_SIZE);
  assign oob      = base_end > (BASE_W + 1)'(MEMORY_SIZE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (do_access) begin
      err_q <= oob;
    end
  end

  assign err = err_q;
`else
  assign oob = 1'b0;
  assign err = 1'b0;
`endif

  assign write_en = do_access && write_q && !oob;

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < OFFSET_SIZE; k++) begin
      rd_next[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[mem_idx + MEM_AW'(k)];
    end
  end

  // ------------------------------------------------------------ storage
  // Storage is never reset; each word powers up holding its index + 1.
  // The base is always block aligned, so a word is written exactly when
  // the selected base equals the first word of its own block.
  for (genvar g = 0; g < MEMORY_SIZE; g++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q = DATA_WIDTH'(g + 1);

    always_ff @(posedge clk_i) begin
      if (write_en && (mem_idx == MEM_AW'(g - (g % OFFSET_SIZE)))) begin
        word_q <= wr_line_q[(g % OFFSET_SIZE)*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign mem_q[g] = word_q;
  end

  // ------------------------------------------------- request / outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy      <= 1'b0;
      ack       <= 1'b0;
      rd_line   <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wr_line_q <= '0;
    end else begin
      busy <= busy_d;
      ack  <= ack_d;
      if (capture) begin
        write_q   <= req_write;
        addr_q    <= req_block_addr;
        wr_line_q <= wr_line;
      end
      if (do_access && !write_q) begin
        rd_line <= oob ? '0 : rd_next;
      end
    end
  end

endmodule
